stopwatch_input_ctrl: RTL and testbench
=======================================

// Module: stopwatch_input_ctrl
// PURPOSE
//  Front end of the stopwatch: turns raw board buttons/switches into the clean mode
//  levels the stopwatch core consumes (regular/adjust-seconds/adjust-minutes/pause)
//  plus a one-cycle clear pulse. Synchronises, debounces, edge-detects buttons and
//  holds the pause toggle state. Sits between board pins and the stopwatch top.
// PARAMETERS
//  DB_CYCLES  1_000_000  consecutive stable clk cycles required to accept a new level (10 ms @ 100 MHz)
//  CNT_W      $clog2(DB_CYCLES+1)  debounce counter width (derived, do not override)
// PORTS
//  clk           in   1  master clock, single clock domain
//  rst           in   1  synchronous, active-high reset
//  btn_pause     in   1  raw pause push-button, asynchronous, bouncy
//  btn_clear     in   1  raw clear push-button, asynchronous, bouncy
//  sw_adj        in   1  raw adjust switch (1 = adjust)
//  sw_sel        in   1  raw select switch (1 = seconds, 0 = minutes)
//  regular_mode         out 1  one-hot mode output
//  adjust_seconds_mode  out 1  one-hot mode output
//  adjust_minutes_mode  out 1  one-hot mode output
//  pause_mode           out 1  one-hot mode output
//  clear_pulse          out 1  one-cycle pulse per accepted clear press
// BEHAVIOUR
//  - Each raw input: 2-flop synchroniser, then debouncer. Counter counts while the
//    synced level differs from the debounced level; any agreeing cycle zeroes it.
//    When the count reaches DB_CYCLES the debounced level flips and the counter zeroes.
//  - Latency: debounced level changes 2+DB_CYCLES clk edges after raw is first sampled
//    at its new level (when held stable). All outputs registered: +1 cycle, total 3+DB_CYCLES.
//  - Glitches shorter than DB_CYCLES cycles produce no output change.
//  - Button press = rising edge of debounced level. Holding a button yields exactly one event.
//    Release produces no event.
//  - paused flag: toggles on each pause press. Cleared to 0 on a clear press.
//  - Pause press and clear press in the same cycle: clear wins; paused=0, clear_pulse=1.
//  - Mode decode, priority order:
//    1. sw_adj=1: adjust_seconds_mode=sw_sel, adjust_minutes_mode=~sw_sel.
//    2. Else if paused: pause_mode.
//    3. Else: regular_mode.
//    Exactly one mode output is high every cycle, including during and after reset.
//  - Pause presses during adjust still toggle paused. The effect is visible once sw_adj returns to 0.
//  - clear_pulse is high for exactly 1 cycle per accepted clear press, independent of mode.
//  - Reset values: synchroniser and debounced states 0, counters 0, paused 0,
//    regular_mode=1, all other outputs 0.
//  - Reset mid-debounce discards partial counts.
//  - A button held across reset release is seen as a fresh press after 2+DB_CYCLES cycles.
//    This is the required behaviour.
// STRUCTURE
//  - Shared package: mode one-hot index constants (MODE_REG, MODE_ADJ_SEC, MODE_ADJ_MIN,
//    MODE_PAUSE) and the default DB_CYCLES for 100 MHz. The display and counter blocks use the same constants.
//  - One sub-module: input_debouncer (params DB_CYCLES; ports clk, rst, raw, level, rise).
//    It contains the synchroniser, counter and rising-edge detector. Instantiated 4 times.
//  - Top of this block: paused register, clear/toggle arbitration, registered mode decode.
// TESTING  (bench uses DB_CYCLES=4)
//  1. Reset asserted 3 cycles, all raw 0 -> regular_mode=1, others 0, clear_pulse=0 every cycle.
//  2. btn_pause high 3 cycles then low -> no output change ever.
//     btn_pause held high 20 cycles -> pause_mode rises exactly 7 cycles after first sample, stays.
//  3. Second pause press (held 10 cycles) -> back to regular_mode.
//     Bounce pattern 1,0,1,1,0 before the stable level -> still exactly one toggle.
//  4. Paused, then btn_pause and btn_clear rise same cycle, held 10 -> clear_pulse one cycle,
//     regular_mode=1.
//  5. sw_adj=1, sw_sel=1 -> adjust_seconds_mode=1. Then sw_sel=0 -> adjust_minutes_mode=1.
//     Pause press while adjusting, then sw_adj=0 -> pause_mode=1.
//  6. Assert rst while a press is 2 counts into debounce, keep button held -> after release,
//     press accepted 6 cycles later. Check one-hot invariant holds on every cycle of all tests.

Source files
------------

// File: rtl/stopwatch_input_ctrl_pkg.sv
// Shared constants for the stopwatch: one-hot mode bit positions and default timing.
// Display and counter blocks import the same mode indices.
package stopwatch_input_ctrl_pkg;

  localparam int MODE_W       = 4;
  localparam int MODE_REG     = 0;
  localparam int MODE_ADJ_SEC = 1;
  localparam int MODE_ADJ_MIN = 2;
  localparam int MODE_PAUSE   = 3;

  // 10 ms of stability at 100 MHz
  localparam int DB_CYCLES_100MHZ = 1_000_000;

  // Raw input positions inside the debouncer bank
  localparam int IN_PAUSE = 0;
  localparam int IN_CLEAR = 1;
  localparam int IN_ADJ   = 2;
  localparam int IN_SEL   = 3;
  localparam int IN_COUNT = 4;

  function automatic logic [MODE_W-1:0] mode_onehot(input int idx);
    logic [MODE_W-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser, stability-count debouncer and rising-edge detector
// for a single raw board input.
import stopwatch_input_ctrl_pkg::*;

module input_debouncer #(
  parameter int DB_CYCLES = DB_CYCLES_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             rise_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      // Any cycle that agrees with the accepted level restarts the stability count
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_inc == CNT_W'(DB_CYCLES)) begin
        level_reg <= ~level_reg;
        rise_reg  <= ~level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_inc;
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/stopwatch_input_ctrl.sv
// Stopwatch front end: debounces buttons/switches, holds the pause toggle and
// produces registered one-hot mode levels plus a one-cycle clear pulse.
import stopwatch_input_ctrl_pkg::*;

module stopwatch_input_ctrl #(
  parameter int DB_CYCLES = DB_CYCLES_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pause,
  input  logic btn_clear,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic regular_mode,
  output logic adjust_seconds_mode,
  output logic adjust_minutes_mode,
  output logic pause_mode,
  output logic clear_pulse
);

  logic [IN_COUNT-1:0] raw_vec;
  logic [IN_COUNT-1:0] level_vec;
  logic [IN_COUNT-1:0] rise_vec;

  assign raw_vec[IN_PAUSE] = btn_pause;
  assign raw_vec[IN_CLEAR] = btn_clear;
  assign raw_vec[IN_ADJ]   = sw_adj;
  assign raw_vec[IN_SEL]   = sw_sel;

  generate
    for (genvar gi = 0; gi < IN_COUNT; gi++) begin : g_db
      input_debouncer #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_vec[gi]),
        .level(level_vec[gi]),
        .rise (rise_vec[gi])
      );
    end
  endgenerate

  // Buttons only matter on press, switches only by level
  logic unused_bits;
  assign unused_bits = &{1'b0, level_vec[IN_PAUSE], level_vec[IN_CLEAR],
                         rise_vec[IN_ADJ], rise_vec[IN_SEL]};

  logic              paused_reg;
  logic              paused_next;
  logic              clear_pulse_reg;
  logic [MODE_W-1:0] mode_reg;
  logic [MODE_W-1:0] mode_next;

  always_comb begin
    paused_next = paused_reg;
    // Clear overrides a simultaneous pause press
    if (rise_vec[IN_CLEAR]) begin
      paused_next = 1'b0;
    end else if (rise_vec[IN_PAUSE]) begin
      paused_next = ~paused_reg;
    end
  end

  always_comb begin
    mode_next = mode_onehot(MODE_REG);
    if (level_vec[IN_ADJ]) begin
      mode_next = level_vec[IN_SEL] ? mode_onehot(MODE_ADJ_SEC) : mode_onehot(MODE_ADJ_MIN);
    end else if (paused_next) begin
      mode_next = mode_onehot(MODE_PAUSE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      paused_reg      <= 1'b0;
      clear_pulse_reg <= 1'b0;
      mode_reg        <= mode_onehot(MODE_REG);
    end else begin
      paused_reg      <= paused_next;
      clear_pulse_reg <= rise_vec[IN_CLEAR];
      mode_reg        <= mode_next;
    end
  end

  assign regular_mode        = mode_reg[MODE_REG];
  assign adjust_seconds_mode = mode_reg[MODE_ADJ_SEC];
  assign adjust_minutes_mode = mode_reg[MODE_ADJ_MIN];
  assign pause_mode          = mode_reg[MODE_PAUSE];
  assign clear_pulse         = clear_pulse_reg;

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Directed bench for stopwatch_input_ctrl with a short debounce window.
module tb_stopwatch_input_ctrl;

  localparam int DB = 4;
  localparam logic [3:0] M_REG = 4'b0001;
  localparam logic [3:0] M_SEC = 4'b0010;
  localparam logic [3:0] M_MIN = 4'b0100;
  localparam logic [3:0] M_PAU = 4'b1000;

  logic clk = 1'b0;
  logic rst, btn_pause, btn_clear, sw_adj, sw_sel;
  logic regular_mode, adjust_seconds_mode, adjust_minutes_mode, pause_mode, clear_pulse;
  logic [3:0] m;

  int total = 0;
  int bad   = 0;
  int clr_cnt = 0;
  bit chk_en = 1'b0;

  stopwatch_input_ctrl #(.DB_CYCLES(DB)) dut (
    .clk                (clk),
    .rst                (rst),
    .btn_pause          (btn_pause),
    .btn_clear          (btn_clear),
    .sw_adj             (sw_adj),
    .sw_sel             (sw_sel),
    .regular_mode       (regular_mode),
    .adjust_seconds_mode(adjust_seconds_mode),
    .adjust_minutes_mode(adjust_minutes_mode),
    .pause_mode         (pause_mode),
    .clear_pulse        (clear_pulse)
  );

  always #5 clk = ~clk;

  assign m = {pause_mode, adjust_minutes_mode, adjust_seconds_mode, regular_mode};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Exactly one mode high on every sampled cycle; also tally clear pulses
  always @(negedge clk) begin
    if (chk_en) begin
      chk("onehot", 32'($countones(m)), 32'd1);
      if (clear_pulse === 1'b1) clr_cnt++;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; btn_pause = 1'b0; btn_clear = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;

    // 1: reset
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_mode", 32'(m), 32'(M_REG));
      chk("rst_clr", 32'(clear_pulse), 32'd0);
    end
    rst = 1'b0;
    cyc();
    $display("t1 reset: mode=%b clear=%b", m, clear_pulse);

    // 2a: short glitch ignored
    btn_pause = 1'b1;
    repeat (3) cyc();
    btn_pause = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk("glitch_mode", 32'(m), 32'(M_REG));
    end
    $display("t2a glitch: mode=%b", m);

    // 2b: held press -> pause 7 cycles after first sample
    btn_pause = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("press1_mode", 32'(m), 32'((k >= 7) ? M_PAU : M_REG));
    end
    btn_pause = 1'b0;
    repeat (10) cyc();
    chk("release1_mode", 32'(m), 32'(M_PAU));
    $display("t2b press: mode=%b", m);

    // 3a: second press -> regular
    btn_pause = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("press2_mode", 32'(m), 32'((k >= 7) ? M_REG : M_PAU));
    end
    btn_pause = 1'b0;
    repeat (10) cyc();
    $display("t3a press2: mode=%b", m);

    // 3b: bouncy press -> exactly one toggle
    begin
      logic [4:0] bounce;
      bounce = 5'b10110;
      for (int i = 4; i >= 0; i--) begin
        btn_pause = bounce[i];
        cyc();
        chk("bounce_mode", 32'(m), 32'(M_REG));
      end
    end
    btn_pause = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("bounce_settle", 32'(m), 32'((k >= 7) ? M_PAU : M_REG));
    end
    btn_pause = 1'b0;
    repeat (10) cyc();
    $display("t3b bounce: mode=%b", m);

    // 4: simultaneous pause+clear while paused -> clear wins
    btn_pause = 1'b1;
    btn_clear = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("both_clr", 32'(clear_pulse), 32'(k == 7));
      chk("both_mode", 32'(m), 32'((k >= 7) ? M_REG : M_PAU));
    end
    btn_pause = 1'b0;
    btn_clear = 1'b0;
    repeat (10) cyc();
    chk("clr_count", 32'(clr_cnt), 32'd1);
    $display("t4 clear: mode=%b clears=%0d", m, clr_cnt);

    // 5: adjust modes
    sw_adj = 1'b1;
    sw_sel = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("adj_sec", 32'(m), 32'((k >= 7) ? M_SEC : M_REG));
    end
    sw_sel = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("adj_min", 32'(m), 32'((k >= 7) ? M_MIN : M_SEC));
    end
    btn_pause = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("adj_press", 32'(m), 32'(M_MIN));
    end
    btn_pause = 1'b0;
    repeat (10) cyc();
    sw_adj = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("adj_exit", 32'(m), 32'((k >= 7) ? M_PAU : M_MIN));
    end
    $display("t5 adjust: mode=%b", m);

    // 6: reset two counts into debounce, button held through
    btn_pause = 1'b1;
    repeat (4) cyc();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("mid_rst_mode", 32'(m), 32'(M_REG));
      chk("mid_rst_clr", 32'(clear_pulse), 32'd0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("post_rst", 32'(m), 32'((k >= 7) ? M_PAU : M_REG));
    end
    btn_pause = 1'b0;
    repeat (10) cyc();
    chk("final_mode", 32'(m), 32'(M_PAU));
    chk("final_clr", 32'(clr_cnt), 32'd1);
    $display("t6 reset-held: mode=%b", m);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
